sar_conv_sequencer: RTL and testbench

- Initiator side of the SAR conversion handshake: pulses `cnvst`, waits for the `eoc` pulse from the SAR logic and captures the 10-bit `sar` code on it.
- Averages 2^AVG_LOG2 conversions and hands the result downstream over a valid/ready interface.
- Enforces a fixed conversion period and a per-conversion timeout.
- Sits between the SAR logic block and the digital readout path.

---
 rtl/sar_conv_sequencer.sv | 137 +++++++++++++
 tb/tb_sar_conv_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sar_conv_sequencer.sv
// SAR conversion sequencer: cnvst/eoc handshake, averaging, valid/ready output.
// Define SAR_SEQ_ROUND_EN to round-to-nearest (saturating) instead of truncating.
module sar_conv_sequencer #(
    parameter int DATA_W   = 10,
    parameter int AVG_LOG2 = 2,
    parameter int PERIOD   = 64,
    parameter int TIMEOUT  = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              cnvst,
    input  logic              eoc,
    input  logic [DATA_W-1:0] sar,
    output logic [DATA_W-1:0] res_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              timeout_err,
    output logic              busy
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = ((AVG_LOG2 > 1) ? AVG_LOG2 : 1) + 1;
    localparam int PER_W = $clog2(PERIOD);
    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] NSAMP    = CNT_W'(1 << AVG_LOG2);
    // Counters load 0 in START, so the limit is hit one count early.
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD - 2);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_NEXT   = 3'd3;
    localparam logic [2:0] S_OUTPUT = 3'd4;

    logic [2:0]        state;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic [PER_W-1:0]  per;
    logic [TMO_W-1:0]  tmo;
    logic [DATA_W-1:0] avg;

    assign busy = (state != S_IDLE);

    generate
        if (AVG_LOG2 == 0) begin : g_noavg
            assign avg = acc;
        end else begin : g_avg
`ifdef SAR_SEQ_ROUND_EN
            // (acc + half) >> k equals (acc >> k) plus the bit just below.
            logic [DATA_W:0] rnd;
            assign rnd = {1'b0, acc[ACC_W-1:AVG_LOG2]}
                       + (DATA_W+1)'(acc[AVG_LOG2-1]);
            assign avg = rnd[DATA_W] ? '1 : rnd[DATA_W-1:0];
`else
            assign avg = acc[ACC_W-1:AVG_LOG2];
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnvst       <= 1'b0;
            res_data    <= '0;
            res_valid   <= 1'b0;
            timeout_err <= 1'b0;
            acc         <= '0;
            cnt         <= '0;
            per         <= '0;
            tmo         <= '0;
        end else begin
            cnvst <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state <= S_START;
                        cnvst <= 1'b1;
                        acc   <= '0;
                        cnt   <= '0;
                    end else begin
                        timeout_err <= 1'b0;
                    end
                end
                S_START: begin
                    per   <= '0;
                    tmo   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    tmo <= tmo + TMO_W'(1);
                    per <= per + PER_W'(1);
                    if (eoc) begin
                        acc   <= acc + ACC_W'(sar);
                        cnt   <= cnt + CNT_W'(1);
                        state <= S_NEXT;
                    end else if (tmo == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        acc         <= '0;
                        cnt         <= '0;
                        state       <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    per <= per + PER_W'(1);
                    if (cnt == NSAMP) begin
                        res_data  <= avg;
                        res_valid <= 1'b1;
                        state     <= S_OUTPUT;
                    end else if (!enable) begin
                        state <= S_IDLE;
                    end else if (per == PER_LAST) begin
                        state <= S_START;
                        cnvst <= 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                        if (enable) begin
                            state <= S_START;
                            cnvst <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Directed bench for sar_conv_sequencer with a behavioural SAR model.
module tb_sar_conv_sequencer;

    localparam int DW = 10;
`ifdef SAR_SEQ_ROUND_EN
    localparam int EXP1 = 102;
    localparam int EXP2 = 26;
    localparam int EXP3 = 501;
`else
    localparam int EXP1 = 101;
    localparam int EXP2 = 25;
    localparam int EXP3 = 500;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          enable = 1'b0;
    logic          eoc = 1'b0;
    logic          res_ready = 1'b0;
    logic [DW-1:0] sar = '0;
    logic          cnvst;
    logic          res_valid;
    logic          timeout_err;
    logic          busy;
    logic [DW-1:0] res_data;

    sar_conv_sequencer dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .cnvst(cnvst), .eoc(eoc), .sar(sar),
        .res_data(res_data), .res_valid(res_valid),
        .res_ready(res_ready), .timeout_err(timeout_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    int dly[64];
    int code[64];
    bit stray[64];
    int cst[64];
    int ecyc[64];
    int ncst = 0;
    int tmo_rise = -1;
    logic tmo_q = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input int lim, output int vc);
        vc = -1;
        for (int i = 0; i < lim; i++) begin
            tick(1);
            if (res_valid) begin
                vc = cyc;
                break;
            end
        end
        check("valid_seen", int'(vc >= 0), 1);
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (cnvst && ncst < 64) begin
                cst[ncst] = cyc;
                ncst++;
            end
            if (timeout_err && !tmo_q && tmo_rise < 0)
                tmo_rise = cyc;
            tmo_q = timeout_err;
        end
    end

    initial begin : sar_model
        int m;
        int k;
        m = 0;
        forever begin
            @(posedge clk);
            #1;
            if (cnvst && rst_n && m < 64) begin
                k = m;
                m++;
                if (dly[k] > 0) begin
                    tick(dly[k]);
                    eoc = 1'b1;
                    sar = DW'(code[k]);
                    ecyc[k] = cyc;
                    tick(1);
                    eoc = 1'b0;
                    if (stray[k]) begin
                        tick(1);
                        eoc = 1'b1;
                        sar = '1;
                        tick(1);
                        eoc = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : main
        int vc;
        int en_c;
        bit ok;
        bit saw;
        for (int i = 0; i < 64; i++) begin
            dly[i] = 20;
            code[i] = 0;
            stray[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) code[i] = 100 + i;
        code[4] = 200;
        dly[5] = 0;
        code[6] = 10; code[7] = 20; code[8] = 31; code[9] = 41;
        code[10] = 300;
        code[11] = 301; dly[11] = 30;
        code[12] = 500; dly[12] = 47; stray[12] = 1'b1;
        code[13] = 500; code[14] = 500; code[15] = 502;

        #1 rst_n = 1'b0;
        tick(2);
        check("rst_cnvst", int'(cnvst), 0);
        check("rst_valid", int'(res_valid), 0);
        check("rst_data", int'(res_data), 0);
        check("rst_tmo", int'(timeout_err), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick(2);
        check("idle_busy", int'(busy), 0);

        // basic averaging, then hold the result under backpressure
        enable = 1'b1;
        en_c = cyc;
        wait_valid(400, vc);
        check("first_cnvst", cst[0], en_c + 1);
        for (int i = 1; i < 4; i++)
            check("spacing", cst[i] - cst[i-1], 64);
        check("avg1", int'(res_data), EXP1);
        check("latency", vc - ecyc[3], 2);
        ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (res_data !== DW'(EXP1) || !res_valid) ok = 1'b0;
        end
        check("bp_hold", int'(ok), 1);
        check("bp_no_cnvst", ncst, 4);
        res_ready = 1'b1;
        tick(1);
        check("acc_cnvst", int'(cnvst), 1);
        check("acc_valid", int'(res_valid), 0);

        // timeout on the second conversion discards the partial sum
        wait_valid(800, vc);
        check("avg2", int'(res_data), EXP2);
        check("tmo_cycle", tmo_rise - cst[5], 48);
        check("tmo_sticky", int'(timeout_err), 1);
        check("tmo_ncst", ncst, 10);
        check("tmo_spacing", cst[6] - cst[5], 64);

        // enable dropped during the second sample's conversion
        for (int i = 0; i < 200; i++) begin
            if (ncst >= 12) break;
            tick(1);
        end
        check("drop_start", ncst, 12);
        tick(10);
        enable = 1'b0;
        tick(5);
        check("drop_busy_wait", int'(busy), 1);
        saw = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (res_valid) saw = 1'b1;
        end
        check("drop_idle", int'(busy), 0);
        check("drop_no_valid", int'(saw), 0);
        check("drop_tmo_clr", int'(timeout_err), 0);
        check("drop_ncst", ncst, 12);

        // eoc on the last legal cycle, stray eoc in NEXT
        res_ready = 1'b0;
        enable = 1'b1;
        wait_valid(600, vc);
        check("race_delay", ecyc[12] - cst[12], 47);
        check("avg3", int'(res_data), EXP3);
        check("race_tmo", int'(timeout_err), 0);
        check("race_ncst", ncst, 16);

        // asynchronous reset while a result is pending
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", int'(res_valid), 0);
        check("arst_cnvst", int'(cnvst), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_data", int'(res_data), 0);
        check("arst_tmo", int'(timeout_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
